// File: rtl/sram_arbiter.sv
// Arbiter and response router for the SRAM shared by the IFU and LSU.
// Define SRAM_ARB_STARVE_GUARD_EN to force an IFU grant after STARVE_MAX back-to-back LSU wins.
module sram_arbiter #(
  parameter int unsigned AW         = 15,
  parameter int unsigned DW         = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ifu_req_valid,
  output logic            ifu_req_ready,
  input  logic [AW-1:0]   ifu_req_addr,
  output logic            ifu_rsp_valid,
  output logic [DW-1:0]   ifu_rsp_data,
  input  logic            lsu_req_valid,
  output logic            lsu_req_ready,
  input  logic            lsu_req_wen,
  input  logic [DW/8-1:0] lsu_req_wmask,
  input  logic [AW-1:0]   lsu_req_addr,
  input  logic [DW-1:0]   lsu_req_wdata,
  output logic            lsu_rsp_valid,
  output logic [DW-1:0]   lsu_rsp_data,
  output logic            ram_cs,
  output logic            ram_w_en,
  output logic [DW/8-1:0] ram_wmask,
  output logic [AW-1:0]   ram_addr,
  output logic [DW-1:0]   ram_wdata,
  input  logic [DW-1:0]   ram_dout
);

  typedef enum logic [1:0] {StIdle, StRspIfu, StRspLsuRd, StRspLsuWr} rsp_state_e;

  rsp_state_e state_q;
  logic       grant_ifu;
  logic       grant_lsu;
  logic       force_ifu;

`ifdef SRAM_ARB_STARVE_GUARD_EN
  localparam int unsigned CW = $clog2(STARVE_MAX + 1);

  logic [CW-1:0] starve_cnt_q;

  assign force_ifu = ifu_req_valid && lsu_req_valid && (starve_cnt_q == CW'(STARVE_MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= '0;
    end else if (grant_ifu || !ifu_req_valid) begin
      starve_cnt_q <= '0;
    end else if (grant_lsu) begin
      starve_cnt_q <= starve_cnt_q + 1'b1;
    end
  end
`else
  assign force_ifu = 1'b0;
`endif

  // Gating with rst_n keeps the SRAM port quiet while reset is held.
  always_comb begin
    grant_lsu = rst_n && lsu_req_valid && !force_ifu;
    grant_ifu = rst_n && ifu_req_valid && !grant_lsu;
  end

  assign ifu_req_ready = grant_ifu;
  assign lsu_req_ready = grant_lsu;

  always_comb begin
    ram_cs    = 1'b0;
    ram_w_en  = 1'b0;
    ram_wmask = '0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (grant_lsu) begin
      ram_cs    = 1'b1;
      ram_w_en  = lsu_req_wen;
      ram_wmask = lsu_req_wen ? lsu_req_wmask : '0;
      ram_addr  = lsu_req_addr;
      ram_wdata = lsu_req_wen ? lsu_req_wdata : '0;
    end else if (grant_ifu) begin
      ram_cs   = 1'b1;
      ram_addr = ifu_req_addr;
    end
  end

  // Response owner for the access granted last cycle; valids are registered alongside it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      ifu_rsp_valid <= 1'b0;
      lsu_rsp_valid <= 1'b0;
    end else begin
      ifu_rsp_valid <= grant_ifu;
      lsu_rsp_valid <= grant_lsu;
      if (grant_lsu) begin
        state_q <= lsu_req_wen ? StRspLsuWr : StRspLsuRd;
      end else if (grant_ifu) begin
        state_q <= StRspIfu;
      end else begin
        state_q <= StIdle;
      end
    end
  end

  assign ifu_rsp_data = (state_q == StRspIfu)   ? ram_dout : '0;
  assign lsu_rsp_data = (state_q == StRspLsuRd) ? ram_dout : '0;

endmodule
